id_scan_ctrl: RTL and testbench

- Sequencer for the identifier recognizer: buffers a character string written through a valid/ready port, then on `start` streams it one character per cycle into the recognizer FSM.
- Collects match statistics and signals completion.
- Sits between a host/loader and the recognizer, replacing hand-driven character stimulus with a controlled run.

---
 rtl/id_scan_pkg.sv | 33 +++
 rtl/id_scan_ctrl_recognizer.sv | 40 ++++
 rtl/id_scan_ctrl.sv | 113 +++++++++++
 tb/tb_id_scan_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_scan_pkg.sv
// Shared types and character-class helpers for the identifier scan
// sequencer and its recognizer FSM.
package id_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ctrl_t;

    typedef enum logic [1:0] {
        S0,
        S1,
        S2
    } rec_t;

    localparam logic [7:0] LC_LO = 8'h61;
    localparam logic [7:0] LC_HI = 8'h7a;
    localparam logic [7:0] UC_LO = 8'h41;
    localparam logic [7:0] UC_HI = 8'h5a;
    localparam logic [7:0] DG_LO = 8'h30;
    localparam logic [7:0] DG_HI = 8'h39;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= LC_LO && c <= LC_HI) ||
               (c >= UC_LO && c <= UC_HI);
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return c >= DG_LO && c <= DG_HI;
    endfunction

endpackage

// File: rtl/id_scan_ctrl_recognizer.sv
// Three-state Moore identifier recognizer; exposes the next-state
// MATCH indication so the sequencer can count hits on the same edge.
module id_recognizer
    import id_scan_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] char,
    output logic       out,
    output logic       nxt_match
);

    rec_t state;
    rec_t nxt;

    always_comb begin
        nxt = S0;
        if (is_letter(char)) begin
            nxt = S1;
        end else if (is_digit(char)) begin
            nxt = (state == S0) ? S0 : S2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S0;
        end else if (clr) begin
            state <= S0;
        end else if (en) begin
            state <= nxt;
        end
    end

    assign out       = (state == S2);
    assign nxt_match = en && (nxt == S2);

endmodule

// File: rtl/id_scan_ctrl.sv
// Buffers a host-written string, then streams it one character per
// cycle through the recognizer while counting matches.
module id_scan_ctrl
    import id_scan_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          out,
    output logic [AW:0]   hit_cnt,
    output logic [AW:0]   id_cnt
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW + 1)'(1);

    ctrl_t       state;
    ctrl_t       nxt_state;
    logic [AW:0] len;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        wr_en;
    logic        run_last;
    logic        clr;
    logic        en;
    logic        nxt_match;

    assign wr_ready = (state == IDLE) && (len < FULL) && !start;
    assign wr_en    = wr_valid && wr_ready;
    assign en       = (state == RUN);
    assign clr      = (state == IDLE) && start && (len != '0);
    assign run_last = (rd_ptr == len - ONE);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_comb begin
        nxt_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt_state = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (run_last) begin
                    nxt_state = DONE;
                end
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            len     <= '0;
            rd_ptr  <= '0;
            hit_cnt <= '0;
            id_cnt  <= '0;
        end else begin
            state <= nxt_state;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rd_ptr  <= '0;
                        hit_cnt <= '0;
                        id_cnt  <= '0;
                    end else if (wr_en) begin
                        len <= len + ONE;
                    end
                end
                RUN: begin
                    rd_ptr <= rd_ptr + ONE;
                    if (nxt_match) begin
                        hit_cnt <= hit_cnt + ONE;
                    end
                    // a new identifier starts only on entry into MATCH
                    if (nxt_match && !out) begin
                        id_cnt <= id_cnt + ONE;
                    end
                end
                DONE:    len <= '0;
                default: len <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[len[AW-1:0]] <= wr_data;
        end
    end

    id_recognizer u_rec (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .en        (en),
        .char      (mem[rd_ptr[AW-1:0]]),
        .out       (out),
        .nxt_match (nxt_match)
    );

endmodule

// File: tb/tb_id_scan_ctrl.sv
// Directed bench for id_scan_ctrl: queue-based string model checked
// every cycle, plus hand-computed expectations per scenario.
module tb_id_scan_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          start;
    logic          busy;
    logic          done;
    logic          out;
    logic [AW:0]   hit_cnt;
    logic [AW:0]   id_cnt;

    id_scan_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .hit_cnt  (hit_cnt),
        .id_cnt   (id_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // string-level model: a queue of characters and a scan cursor
    byte unsigned mq[$];
    int run_idx = -1;
    bit m_done  = 0;
    int m_rs    = 0;
    int m_hit   = 0;
    int m_id    = 0;

    function automatic int step(input int s, input byte unsigned c);
        if ((c >= "a" && c <= "z") || (c >= "A" && c <= "Z")) return 1;
        if (c >= "0" && c <= "9") return (s == 0) ? 0 : 2;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            run_idx = -1;
            m_done  = 0;
            m_rs    = 0;
            m_hit   = 0;
            m_id    = 0;
        end else if (m_done) begin
            m_done = 0;
            mq.delete();
        end else if (run_idx >= 0) begin
            int ns;
            ns = step(m_rs, mq[run_idx]);
            if (ns == 2) m_hit++;
            if (ns == 2 && m_rs != 2) m_id++;
            m_rs = ns;
            run_idx++;
            if (run_idx == mq.size()) begin
                run_idx = -1;
                m_done  = 1;
            end
        end else if (start) begin
            m_hit = 0;
            m_id  = 0;
            if (mq.size() > 0) begin
                run_idx = 0;
                m_rs    = 0;
            end else begin
                m_done = 1;
            end
        end else if (wr_valid && mq.size() < DEPTH) begin
            mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(run_idx >= 0));
        check("done", 32'(done), 32'(m_done));
        check("out", 32'(out), 32'(m_rs == 2));
        check("hit_cnt", 32'(hit_cnt), 32'(m_hit));
        check("id_cnt", 32'(id_cnt), 32'(m_id));
        if (!reset) begin
            check("wr_ready", 32'(wr_ready),
                  32'(!m_done && run_idx < 0 && mq.size() < DEPTH && !start));
        end
    end

    task automatic write_str(input string s);
        @(posedge clk);
        #2;
        for (int i = 0; i < s.len(); i++) begin
            wr_valid = 1'b1;
            wr_data  = s[i];
            @(posedge clk);
            #2;
        end
        wr_valid = 1'b0;
    endtask

    task automatic run_scan(input bit with_wr, output int lat,
                            output int nbusy);
        int t;
        bit got;
        got   = 0;
        nbusy = 0;
        lat   = -1;
        @(posedge clk);
        #2;
        start = 1'b1;
        if (with_wr) begin
            wr_valid = 1'b1;
            wr_data  = "9";
        end
        @(posedge clk);
        #1;
        t = cyc;
        #1;
        start    = 1'b0;
        wr_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = cyc - t;
                got = 1;
                break;
            end
        end
        if (!got) check("done_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int lat;
        int nb;
        int acc;
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        start    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_hit", 32'(hit_cnt), 32'(0));
        check("rst_ready", 32'(wr_ready), 32'(1));

        write_str("abcd12341/");
        run_scan(0, lat, nb);
        check("t1_lat", 32'(lat), 32'(10));
        check("t1_busy", 32'(nb), 32'(10));
        check("t1_hit", 32'(hit_cnt), 32'(5));
        check("t1_id", 32'(id_cnt), 32'(1));
        check("t1_out", 32'(out), 32'(0));

        write_str("a1b2");
        run_scan(0, lat, nb);
        check("t2_hit", 32'(hit_cnt), 32'(2));
        check("t2_id", 32'(id_cnt), 32'(2));
        check("t2_out", 32'(out), 32'(1));

        write_str("12ab");
        run_scan(0, lat, nb);
        check("t3_hit", 32'(hit_cnt), 32'(0));
        check("t3_id", 32'(id_cnt), 32'(0));
        check("t3_out", 32'(out), 32'(0));

        run_scan(0, lat, nb);
        check("t4_lat", 32'(lat), 32'(0));
        check("t4_busy", 32'(nb), 32'(0));
        check("t4_hit", 32'(hit_cnt), 32'(0));

        // 17 offered writes from empty, the last one is '/'
        @(posedge clk);
        #2;
        acc = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            string pat;
            pat = "a123456789012345/";
            wr_data = pat[i];
            @(negedge clk);
            if (wr_valid && wr_ready) acc++;
            if (i == 16) check("t5_ready17", 32'(wr_ready), 32'(0));
            @(posedge clk);
            #2;
        end
        wr_valid = 1'b0;
        check("t5_accepted", 32'(acc), 32'(16));
        run_scan(0, lat, nb);
        check("t5_lat", 32'(lat), 32'(16));
        check("t5_hit", 32'(hit_cnt), 32'(15));
        check("t5_id", 32'(id_cnt), 32'(1));

        write_str("ab");
        run_scan(1, lat, nb);
        check("t5b_lat", 32'(lat), 32'(2));
        check("t5b_hit", 32'(hit_cnt), 32'(0));

        write_str("abc123");
        @(posedge clk);
        #2;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_done", 32'(done), 32'(0));
        check("t6_out", 32'(out), 32'(0));
        check("t6_cnt", 32'({hit_cnt, id_cnt}), 32'(0));
        @(posedge clk);
        #2;
        reset = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) acc++;
        end
        check("t6_nodone", 32'(acc), 32'(0));
        write_str("x9");
        run_scan(0, lat, nb);
        check("t6_lat", 32'(lat), 32'(2));
        check("t6_hit", 32'(hit_cnt), 32'(1));
        check("t6_id", 32'(id_cnt), 32'(1));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
